// File: rtl/iq_issue_ctrl.sv
// iq_issue_ctrl: in-order dual-issue controller for the IR-stage instruction queue.
// Each cycle it looks at the two oldest queue entries and pops 0, 1 or 2 of them.
// Entry 1 only goes out alongside entry 0, and only when:
//   - there is no RAW dependence on entry 0's destination, and
//   - the two entries do not compete for a single-instance unit.
// A flush blanks issue for FLUSH_CYCLES cycles, and each new flush restarts that window.
// Ports:
//   clk_i, rst_i      : clock, async active-high reset
//   flush_i           : pipeline flush request
//   head_valid_i      : valid bit per head entry (entry 0 oldest)
//   head_unit_i       : functional-unit class per entry
//   head_rd_i/rs1/rs2 : register indices per entry
//   head_rd_we_i      : entry writes rd
//   issue_ready_i     : downstream lane can accept
//   read_head_o       : pop strobe / issue-valid per lane (combinational)
//   iq_flush_o        : flush_i delayed one cycle, to the queue
//   state_o           : 0=INIT, 1=RUN, 2=FLUSH
//   stall_cnt_o       : saturating count of RUN cycles with a valid head and no pop
//   dual_cnt_o        : saturating count of dual-issue cycles
//
// state | meaning
// INIT  | one cycle after reset, no issue
// RUN   | normal issue
// FLUSH | blackout after a flush, no issue
module iq_issue_ctrl #(
    parameter int TYPE_W = 4,
    parameter int REG_W = 5,
    parameter logic [(1<<TYPE_W)-1:0] SINGLE_UNIT_MASK = 16'h0030,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic [1:0]          head_valid_i,
    input  logic [2*TYPE_W-1:0] head_unit_i,
    input  logic [2*REG_W-1:0]  head_rd_i,
    input  logic [2*REG_W-1:0]  head_rs1_i,
    input  logic [2*REG_W-1:0]  head_rs2_i,
    input  logic [1:0]          head_rd_we_i,
    input  logic [1:0]          issue_ready_i,
    output logic [1:0]          read_head_o,
    output logic                iq_flush_o,
    output logic [1:0]          state_o,
    output logic [15:0]         stall_cnt_o,
    output logic [15:0]         dual_cnt_o
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             iq_flush_q;
    logic [15:0]      stall_q, stall_d;
    logic [15:0]      dual_q, dual_d;

    logic [TYPE_W-1:0] unit0, unit1;
    logic [REG_W-1:0]  rd0, rs1_1, rs2_1;
    logic              raw_hazard, unit_conflict;
    logic              lane0_go, lane1_go;

    // Entry 0's sources and entry 1's destination never affect pairing decisions.
    logic unused_fields;
    assign unused_fields = ^{head_rd_i[2*REG_W-1:REG_W], head_rs1_i[REG_W-1:0],
                             head_rs2_i[REG_W-1:0], head_rd_we_i[1]};

    assign unit0 = head_unit_i[TYPE_W-1:0];
    assign unit1 = head_unit_i[2*TYPE_W-1:TYPE_W];
    assign rd0   = head_rd_i[REG_W-1:0];
    assign rs1_1 = head_rs1_i[2*REG_W-1:REG_W];
    assign rs2_1 = head_rs2_i[2*REG_W-1:REG_W];

    // x0 is hardwired zero, so writing it creates no dependence.
    assign raw_hazard = head_rd_we_i[0] && (rd0 != '0) && ((rs1_1 == rd0) || (rs2_1 == rd0));
    assign unit_conflict = (unit0 == unit1) && SINGLE_UNIT_MASK[unit0];

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (flush_i) begin
            state_d = ST_FLUSH;
            fcnt_d  = CNT_W'(FLUSH_CYCLES - 1);
        end else begin
            case (state_q)
                ST_INIT: state_d = ST_RUN;
                ST_RUN:  state_d = ST_RUN;
                ST_FLUSH: begin
                    if (fcnt_q == '0) state_d = ST_RUN;
                    else              fcnt_d  = fcnt_q - CNT_W'(1);
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    // Output logic
    always_comb begin
        lane0_go = 1'b0;
        lane1_go = 1'b0;
        if (state_q == ST_RUN && !flush_i) begin
            lane0_go = head_valid_i[0] && issue_ready_i[0];
            lane1_go = lane0_go && head_valid_i[1] && issue_ready_i[1]
                       && !raw_hazard && !unit_conflict;
        end
    end

    assign read_head_o = {lane1_go, lane0_go};

    always_comb begin
        stall_d = stall_q;
        dual_d  = dual_q;
        if (state_q == ST_RUN && head_valid_i[0] && !lane0_go && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
        if (lane1_go && dual_q != 16'hFFFF)
            dual_d = dual_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iq_flush_q <= 1'b0;
            stall_q    <= '0;
            dual_q     <= '0;
        end else begin
            iq_flush_q <= flush_i;
            stall_q    <= stall_d;
            dual_q     <= dual_d;
        end
    end

    assign iq_flush_o  = iq_flush_q;
    assign state_o     = state_q;
    assign stall_cnt_o = stall_q;
    assign dual_cnt_o  = dual_q;

endmodule

// File: tb/tb_iq_issue_ctrl.sv
module tb_iq_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic [1:0]  head_valid_i;
    logic [7:0]  head_unit_i;
    logic [9:0]  head_rd_i, head_rs1_i, head_rs2_i;
    logic [1:0]  head_rd_we_i;
    logic [1:0]  issue_ready_i;
    logic [1:0]  read_head_o;
    logic        iq_flush_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o, dual_cnt_o;

    int n_tests = 0;
    int n_fail = 0;
    logic [15:0] exp_stall = 16'd0;
    logic [15:0] exp_dual = 16'd0;

    iq_issue_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .head_valid_i(head_valid_i), .head_unit_i(head_unit_i),
        .head_rd_i(head_rd_i), .head_rs1_i(head_rs1_i), .head_rs2_i(head_rs2_i),
        .head_rd_we_i(head_rd_we_i), .issue_ready_i(issue_ready_i),
        .read_head_o(read_head_o), .iq_flush_o(iq_flush_o), .state_o(state_o),
        .stall_cnt_o(stall_cnt_o), .dual_cnt_o(dual_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; update the counter model from what this cycle should do.
    task automatic tick(input bit in_run, input logic [1:0] rh);
        if (in_run && head_valid_i[0] && rh == 2'b00 && exp_stall != 16'hFFFF)
            exp_stall = exp_stall + 16'd1;
        if (rh == 2'b11 && exp_dual != 16'hFFFF)
            exp_dual = exp_dual + 16'd1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_heads(input logic [1:0] v, input logic [3:0] u0, input logic [3:0] u1,
                             input logic [4:0] rd0, input logic we0,
                             input logic [4:0] rs1_1, input logic [4:0] rs2_1);
        head_valid_i = v;
        head_unit_i  = {u1, u0};
        head_rd_i    = {5'd9, rd0};
        head_rs1_i   = {rs1_1, 5'd7};
        head_rs2_i   = {rs2_1, 5'd8};
        head_rd_we_i = {1'b1, we0};
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        flush_i = 1'b0;
        issue_ready_i = 2'b11;
        set_heads(2'b11, 4'd0, 4'd1, 5'd1, 1'b1, 5'd2, 5'd3);
        repeat (2) @(posedge clk_i);
        #1;
        n_tests++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state_o); end
        n_tests++; if (read_head_o !== 2'b00) begin n_fail++; $display("FAIL reset_rh got %b exp 00", read_head_o); end
        n_tests++; if (iq_flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_iqf got %b exp 0", iq_flush_o); end
        n_tests++; if (stall_cnt_o !== 16'd0 || dual_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %h/%h exp 0/0", stall_cnt_o, dual_cnt_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        n_tests++; if (read_head_o !== 2'b00) begin n_fail++; $display("FAIL init_rh got %b exp 00", read_head_o); end
        n_tests++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL init_state got %0d exp 0", state_o); end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_dual;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL dual_state[%0d] got %0d exp 1", i, state_o); end
            n_tests++; if (read_head_o !== 2'b11) begin n_fail++; $display("FAIL dual_rh[%0d] got %b exp 11", i, read_head_o); end
            n_tests++; if (dual_cnt_o !== 16'(i)) begin n_fail++; $display("FAIL dual_cnt[%0d] got %0d exp %0d", i, dual_cnt_o, i); end
            tick(1'b1, 2'b11);
        end
    endtask

    task automatic test_raw;
        set_heads(2'b11, 4'd0, 4'd1, 5'd5, 1'b1, 5'd5, 5'd3);
        #1;
        n_tests++; if (read_head_o !== 2'b01) begin n_fail++; $display("FAIL raw_rs1 got %b exp 01", read_head_o); end
        tick(1'b1, 2'b01);
        n_tests++; if (stall_cnt_o !== exp_stall) begin n_fail++; $display("FAIL raw_stall got %0d exp %0d", stall_cnt_o, exp_stall); end
        set_heads(2'b11, 4'd0, 4'd1, 5'd5, 1'b1, 5'd3, 5'd5);
        #1;
        n_tests++; if (read_head_o !== 2'b01) begin n_fail++; $display("FAIL raw_rs2 got %b exp 01", read_head_o); end
        tick(1'b1, 2'b01);
        set_heads(2'b11, 4'd0, 4'd1, 5'd0, 1'b1, 5'd0, 5'd0);
        #1;
        n_tests++; if (read_head_o !== 2'b11) begin n_fail++; $display("FAIL raw_x0 got %b exp 11", read_head_o); end
        tick(1'b1, 2'b11);
        set_heads(2'b11, 4'd0, 4'd1, 5'd5, 1'b0, 5'd5, 5'd5);
        #1;
        n_tests++; if (read_head_o !== 2'b11) begin n_fail++; $display("FAIL raw_nowe got %b exp 11", read_head_o); end
        tick(1'b1, 2'b11);
        n_tests++; if (dual_cnt_o !== exp_dual) begin n_fail++; $display("FAIL raw_dual got %0d exp %0d", dual_cnt_o, exp_dual); end
    endtask

    task automatic test_unit;
        set_heads(2'b11, 4'd4, 4'd4, 5'd1, 1'b1, 5'd2, 5'd3);
        #1;
        n_tests++; if (read_head_o !== 2'b01) begin n_fail++; $display("FAIL unit4 got %b exp 01", read_head_o); end
        tick(1'b1, 2'b01);
        set_heads(2'b11, 4'd5, 4'd5, 5'd1, 1'b1, 5'd2, 5'd3);
        #1;
        n_tests++; if (read_head_o !== 2'b01) begin n_fail++; $display("FAIL unit5 got %b exp 01", read_head_o); end
        tick(1'b1, 2'b01);
        set_heads(2'b11, 4'd2, 4'd2, 5'd1, 1'b1, 5'd2, 5'd3);
        #1;
        n_tests++; if (read_head_o !== 2'b11) begin n_fail++; $display("FAIL unit2 got %b exp 11", read_head_o); end
        tick(1'b1, 2'b11);
        set_heads(2'b11, 4'd4, 4'd5, 5'd1, 1'b1, 5'd2, 5'd3);
        #1;
        n_tests++; if (read_head_o !== 2'b11) begin n_fail++; $display("FAIL unit45 got %b exp 11", read_head_o); end
        tick(1'b1, 2'b11);
    endtask

    task automatic test_ready;
        set_heads(2'b11, 4'd0, 4'd1, 5'd1, 1'b1, 5'd2, 5'd3);
        issue_ready_i = 2'b10;
        #1;
        n_tests++; if (read_head_o !== 2'b00) begin n_fail++; $display("FAIL ready10 got %b exp 00", read_head_o); end
        tick(1'b1, 2'b00);
        n_tests++; if (stall_cnt_o !== exp_stall) begin n_fail++; $display("FAIL ready10_stall got %0d exp %0d", stall_cnt_o, exp_stall); end
        issue_ready_i = 2'b01;
        #1;
        n_tests++; if (read_head_o !== 2'b01) begin n_fail++; $display("FAIL ready01 got %b exp 01", read_head_o); end
        tick(1'b1, 2'b01);
        issue_ready_i = 2'b11;
        head_valid_i = 2'b10;
        #1;
        n_tests++; if (read_head_o !== 2'b00) begin n_fail++; $display("FAIL valid10 got %b exp 00", read_head_o); end
        tick(1'b1, 2'b00);
        head_valid_i = 2'b00;
        #1;
        n_tests++; if (read_head_o !== 2'b00) begin n_fail++; $display("FAIL empty got %b exp 00", read_head_o); end
        tick(1'b1, 2'b00);
        n_tests++; if (stall_cnt_o !== exp_stall) begin n_fail++; $display("FAIL empty_stall got %0d exp %0d", stall_cnt_o, exp_stall); end
        head_valid_i = 2'b11;
    endtask

    task automatic test_flush;
        // Single flush at t
        flush_i = 1'b1;
        #1;
        n_tests++; if (read_head_o !== 2'b00) begin n_fail++; $display("FAIL fl_t_rh got %b exp 00", read_head_o); end
        tick(1'b1, 2'b00);
        flush_i = 1'b0;
        #1;
        n_tests++; if (iq_flush_o !== 1'b1 || state_o !== 2'd2 || read_head_o !== 2'b00) begin n_fail++; $display("FAIL fl_t1 got iqf=%b st=%0d rh=%b exp 1/2/00", iq_flush_o, state_o, read_head_o); end
        tick(1'b0, 2'b00);
        n_tests++; if (iq_flush_o !== 1'b0 || state_o !== 2'd2 || read_head_o !== 2'b00) begin n_fail++; $display("FAIL fl_t2 got iqf=%b st=%0d rh=%b exp 0/2/00", iq_flush_o, state_o, read_head_o); end
        tick(1'b0, 2'b00);
        n_tests++; if (state_o !== 2'd1 || read_head_o !== 2'b11) begin n_fail++; $display("FAIL fl_t3 got st=%0d rh=%b exp 1/11", state_o, read_head_o); end
        tick(1'b1, 2'b11);
        n_tests++; if (stall_cnt_o !== exp_stall || dual_cnt_o !== exp_dual) begin n_fail++; $display("FAIL fl_cnt got %0d/%0d exp %0d/%0d", stall_cnt_o, dual_cnt_o, exp_stall, exp_dual); end
        // Back-to-back flush at t and t+1
        flush_i = 1'b1;
        tick(1'b1, 2'b00);
        #1;
        n_tests++; if (read_head_o !== 2'b00 || state_o !== 2'd2) begin n_fail++; $display("FAIL fl2_t1 got rh=%b st=%0d exp 00/2", read_head_o, state_o); end
        tick(1'b0, 2'b00);
        flush_i = 1'b0;
        #1;
        n_tests++; if (iq_flush_o !== 1'b1 || state_o !== 2'd2) begin n_fail++; $display("FAIL fl2_t2 got iqf=%b st=%0d exp 1/2", iq_flush_o, state_o); end
        tick(1'b0, 2'b00);
        n_tests++; if (iq_flush_o !== 1'b0 || state_o !== 2'd2 || read_head_o !== 2'b00) begin n_fail++; $display("FAIL fl2_t3 got iqf=%b st=%0d rh=%b exp 0/2/00", iq_flush_o, state_o, read_head_o); end
        tick(1'b0, 2'b00);
        n_tests++; if (state_o !== 2'd1 || read_head_o !== 2'b11) begin n_fail++; $display("FAIL fl2_t4 got st=%0d rh=%b exp 1/11", state_o, read_head_o); end
        tick(1'b1, 2'b11);
    endtask

    task automatic test_saturate_and_reset;
        issue_ready_i = 2'b00;
        head_valid_i = 2'b01;
        while (exp_stall != 16'hFFFF) tick(1'b1, 2'b00);
        n_tests++; if (stall_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got %h exp ffff", stall_cnt_o); end
        repeat (3) tick(1'b1, 2'b00);
        n_tests++; if (stall_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h exp ffff", stall_cnt_o); end
        flush_i = 1'b1;
        tick(1'b1, 2'b00);
        flush_i = 1'b0;
        #1;
        n_tests++; if (state_o !== 2'd2 || iq_flush_o !== 1'b1) begin n_fail++; $display("FAIL midfl_pre got st=%0d iqf=%b exp 2/1", state_o, iq_flush_o); end
        rst_i = 1'b1;
        #1;
        n_tests++; if (state_o !== 2'd0 || iq_flush_o !== 1'b0 || read_head_o !== 2'b00) begin n_fail++; $display("FAIL midfl_rst got st=%0d iqf=%b rh=%b exp 0/0/00", state_o, iq_flush_o, read_head_o); end
        n_tests++; if (stall_cnt_o !== 16'd0 || dual_cnt_o !== 16'd0) begin n_fail++; $display("FAIL midfl_cnt got %h/%h exp 0/0", stall_cnt_o, dual_cnt_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        test_reset;
        test_dual;
        test_raw;
        test_unit;
        test_ready;
        test_flush;
        test_saturate_and_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
